alu_host_driver: RTL and testbench
==================================

// Module: alu_host_driver
// PURPOSE
//  Initiator side of the byte-serial ALU operand/result interface (clk, rst, start, sel, inbus, outbus, finish).
//  Takes one command (op, two operands) over a valid/ready handshake and sequences it onto the ALU bus.
//  Waits for finish, then assembles the 1- or 2-byte result and returns it over a valid/ready response port.
//  Sits between the test/host logic and the ALU core; the ALU shares the same clk and rst.
// PARAMETERS
//  WIDTH    8   ALU bus width; operand width; response data is 2*WIDTH
//  TIMEOUT  64  max cycles spent in WAIT before an error response (>=2)
// PORTS
//  clk         in   1        system clock, rising edge
//  rst         in   1        synchronous, active-high reset
//  cmd_valid   in   1        command present
//  cmd_ready   out  1        driver can accept a command (high only in IDLE)
//  cmd_op      in   2        00 add, 01 sub, 10 mul, 11 div
//  cmd_a       in   WIDTH    first operand (A / multiplicand / dividend)
//  cmd_b       in   WIDTH    second operand (M / multiplier / divisor)
//  rsp_valid   out  1        response present
//  rsp_ready   in   1        consumer accepts response
//  rsp_data    out  2*WIDTH  result, see BEHAVIOUR
//  rsp_err     out  1        1 = timeout, rsp_data is 0
//  alu_start   out  1        start pulse to ALU
//  alu_sel     out  2        operation select to ALU
//  alu_inbus   out  WIDTH    operand bus to ALU
//  alu_outbus  in   WIDTH    result bus from ALU
//  alu_finish  in   1        ALU done strobe
// BEHAVIOUR
//  - All outputs registered. Reset (rst=1 at clock edge): state IDLE, cmd_ready=1, all other outputs 0, counters 0.
//  - rst mid-operation aborts any command in flight; no response is produced for it.
//  - FSM: IDLE -> LOAD_A -> LOAD_M -> WAIT -> RESP -> IDLE.
//  - IDLE: on cmd_valid&cmd_ready (cycle T), latch op/a/b. In cycle T+1 cmd_ready=0.
//  - LOAD_A (T+1): alu_start=1, alu_sel=op, alu_inbus=a. alu_start is high for exactly this one cycle.
//  - LOAD_M (T+2): alu_start=0, alu_inbus=b, alu_sel held.
//  - WAIT (T+3..): alu_inbus=0, alu_sel held. A history register hist captures alu_outbus every WAIT cycle.
//    The wait counter increments every WAIT cycle.
//  - alu_finish is ignored outside WAIT.
//  - finish seen in WAIT (cycle F): in F+1, enter RESP with rsp_valid=1, rsp_err=0, and rsp_data as follows:
//      add/sub: {WIDTH'b0, outbus@F}; result wraps mod 2^WIDTH, no carry/borrow reported
//      mul:     {outbus@F-1, outbus@F} = {high byte, low byte}
//      div:     {outbus@F-1, outbus@F} = {remainder, quotient}
//    If F is the first WAIT cycle, outbus@F-1 is taken as 0 (hist cleared on entering WAIT).
//  - Timeout: counter reaches TIMEOUT-1 with no finish -> RESP with rsp_err=1, rsp_data=0.
//    If finish arrives in that same cycle, finish wins and the response is normal.
//  - RESP: rsp_valid, rsp_data and rsp_err stay stable until rsp_valid&rsp_ready.
//    In the next cycle: IDLE, rsp_valid=0, cmd_ready=1.
//    rsp_data is not cleared on handshake and holds its last value.
//  - Exactly one command is outstanding at a time; no command is accepted in the RESP handshake cycle.
//  - alu_sel returns to 00 in IDLE.
// TESTING
//  1 add: op=00 a=40 b=12; ALU model drives outbus=52 with finish at T+5
//    -> alu_start high only at T+1; alu_inbus is 40 at T+1, 12 at T+2; rsp_data=0x0034, err=0 at T+6.
//  2 mul: op=10 a=25 b=13; model drives outbus 0x01 then 0x45 with finish -> rsp_data=0x0145.
//  3 div: op=11 a=100 b=7; model drives 0x02 then 0x0E with finish -> rsp_data=0x020E.
//  4 timeout: model never finishes -> rsp_valid after 64 WAIT cycles, rsp_err=1, rsp_data=0.
//    Repeat with finish on the 64th WAIT cycle -> err=0.
//  5 backpressure: rsp_ready low for 5 cycles -> rsp_* stable and cmd_ready=0 throughout;
//    back-to-back cmd_valid is accepted one cycle after the rsp handshake.
//  6 reset in WAIT: assert rst one cycle
//    -> next cycle all outputs 0, cmd_ready=1; a late finish is ignored and produces no response.

Source files
------------

// File: rtl/alu_host_driver.sv
// Host-side sequencer for the byte-serial ALU bus: accepts one command, loads the
// operands, waits for finish (bounded by TIMEOUT) and returns the assembled result.
module alu_host_driver #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [WIDTH-1:0]   cmd_a,
  input  logic [WIDTH-1:0]   cmd_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2*WIDTH-1:0] rsp_data,
  output logic               rsp_err,
  output logic               alu_start,
  output logic [1:0]         alu_sel,
  output logic [WIDTH-1:0]   alu_inbus,
  input  logic [WIDTH-1:0]   alu_outbus,
  input  logic               alu_finish
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_A = 3'd1;
  localparam logic [2:0] S_LOAD_M = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  localparam int            CW   = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [2:0]       state;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] hist;
  logic [CW-1:0]    cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      alu_start <= 1'b0;
      alu_sel   <= '0;
      alu_inbus <= '0;
      b_q       <= '0;
      hist      <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            b_q       <= cmd_b;
            cmd_ready <= 1'b0;
            alu_start <= 1'b1;
            alu_sel   <= cmd_op;
            alu_inbus <= cmd_a;
            state     <= S_LOAD_A;
          end
        end
        S_LOAD_A: begin
          alu_start <= 1'b0;
          alu_inbus <= b_q;
          state     <= S_LOAD_M;
        end
        S_LOAD_M: begin
          alu_inbus <= '0;
          hist      <= '0;
          cnt       <= '0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          hist <= alu_outbus;
          cnt  <= cnt + 1'b1;
          // finish takes priority over a timeout landing in the same cycle
          if (alu_finish) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_data  <= alu_sel[1] ? {hist, alu_outbus} : {{WIDTH{1'b0}}, alu_outbus};
          end else if (cnt == LAST) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_data  <= '0;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            alu_sel   <= '0;
          end
        end
        default: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_host_driver.sv
// Randomized bench for alu_host_driver; the bench plays the ALU and predicts every
// response from plain arithmetic on the command operands.
module tb_alu_host_driver;

  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 64;

  logic               clk = 1'b0;
  logic               rst;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [WIDTH-1:0]   cmd_a;
  logic [WIDTH-1:0]   cmd_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [2*WIDTH-1:0] rsp_data;
  logic               rsp_err;
  logic               alu_start;
  logic [1:0]         alu_sel;
  logic [WIDTH-1:0]   alu_inbus;
  logic [WIDTH-1:0]   alu_outbus;
  logic               alu_finish;

  int checks = 0;
  int errors = 0;

  alu_host_driver #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .alu_start  (alu_start),
    .alu_sel    (alu_sel),
    .alu_inbus  (alu_inbus),
    .alu_outbus (alu_outbus),
    .alu_finish (alu_finish)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Arithmetic result the ALU would produce: {high/remainder, low/quotient}
  function automatic logic [15:0] full_result(input logic [1:0] op, input logic [7:0] a,
                                              input logic [7:0] b);
    case (op)
      2'd0:    return {8'h00, 8'(a + b)};
      2'd1:    return {8'h00, 8'(a - b)};
      2'd2:    return 16'(a) * 16'(b);
      default: return {a % b, a / b};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // fin_at: WAIT cycle (1-based) carrying finish; 0 means the ALU never finishes.
  // bp: cycles rsp_ready is held low before the handshake.
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                         input int fin_at, input int bp);
    logic [15:0] full;
    logic [15:0] exp_data;
    logic        exp_err;
    int          nwait;
    full     = full_result(op, a, b);
    exp_err  = (fin_at == 0) || (fin_at > TIMEOUT);
    exp_data = exp_err ? 16'h0000 :
               ((op[1] && fin_at > 1) ? full : {8'h00, full[7:0]});
    nwait    = exp_err ? TIMEOUT : fin_at;

    check_eq("idle_ready", 32'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    tick();
    cmd_valid  = 1'b0;
    cmd_op     = 2'($urandom);
    cmd_a      = 8'($urandom);
    cmd_b      = 8'($urandom);
    alu_finish = 1'($urandom);
    check_eq("ldA_start", 32'(alu_start), 1);
    check_eq("ldA_sel",   32'(alu_sel),   32'(op));
    check_eq("ldA_bus",   32'(alu_inbus), 32'(a));
    check_eq("ldA_ready", 32'(cmd_ready), 0);
    tick();
    alu_finish = 1'($urandom);
    check_eq("ldM_start", 32'(alu_start), 0);
    check_eq("ldM_sel",   32'(alu_sel),   32'(op));
    check_eq("ldM_bus",   32'(alu_inbus), 32'(b));
    for (int k = 1; k <= nwait; k++) begin
      tick();
      check_eq("wait_bus",   32'(alu_inbus), 0);
      check_eq("wait_start", 32'(alu_start), 0);
      check_eq("wait_rsp",   32'(rsp_valid), 0);
      check_eq("wait_sel",   32'(alu_sel),   32'(op));
      rsp_ready  = 1'($urandom);
      alu_finish = (k == fin_at);
      if (k == fin_at)                  alu_outbus = full[7:0];
      else if (op[1] && k == fin_at-1)  alu_outbus = full[15:8];
      else                              alu_outbus = 8'($urandom);
    end
    tick();
    alu_finish = 1'b0;
    alu_outbus = 8'($urandom);
    for (int i = 0; i <= bp; i++) begin
      check_eq("rsp_valid", 32'(rsp_valid), 1);
      check_eq("rsp_err",   32'(rsp_err),   32'(exp_err));
      check_eq("rsp_data",  32'(rsp_data),  32'(exp_data));
      check_eq("rsp_ready", 32'(cmd_ready), 0);
      check_eq("rsp_start", 32'(alu_start), 0);
      rsp_ready  = (i == bp);
      cmd_valid  = 1'b1;
      alu_finish = 1'($urandom);
      tick();
    end
    rsp_ready  = 1'b0;
    cmd_valid  = 1'b0;
    alu_finish = 1'b0;
    check_eq("post_valid", 32'(rsp_valid), 0);
    check_eq("post_ready", 32'(cmd_ready), 1);
    check_eq("post_sel",   32'(alu_sel),   0);
    check_eq("post_start", 32'(alu_start), 0);
    check_eq("post_hold",  32'(rsp_data),  32'(exp_data));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, 32'(cmd_ready), 1);
    check_eq({tag, "_valid"}, 32'(rsp_valid), 0);
    check_eq({tag, "_data"},  32'(rsp_data),  0);
    check_eq({tag, "_err"},   32'(rsp_err),   0);
    check_eq({tag, "_start"}, 32'(alu_start), 0);
    check_eq({tag, "_sel"},   32'(alu_sel),   0);
    check_eq({tag, "_bus"},   32'(alu_inbus), 0);
  endtask

  initial begin
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_op     = '0;
    cmd_a      = '0;
    cmd_b      = '0;
    rsp_ready  = 1'b0;
    alu_outbus = '0;
    alu_finish = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check_reset_outputs("reset");

    run_cmd(2'b00, 8'd40,  8'd12, 3, 0);
    run_cmd(2'b10, 8'd25,  8'd13, 2, 0);
    run_cmd(2'b11, 8'd100, 8'd7,  4, 0);
    run_cmd(2'b01, 8'd5,   8'd9,  1, 1);
    run_cmd(2'b10, 8'd200, 8'd200, 1, 0);
    run_cmd(2'b00, 8'd1,   8'd2,  0, 0);
    run_cmd(2'b10, 8'd17,  8'd19, TIMEOUT, 0);
    run_cmd(2'b11, 8'd250, 8'd3,  TIMEOUT + 1, 2);
    run_cmd(2'b01, 8'd3,   8'd4,  2, 5);
    run_cmd(2'b00, 8'd255, 8'd1,  5, 0);

    // reset while waiting for the ALU: late finish must be ignored
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    cmd_a     = 8'd9;
    cmd_b     = 8'd9;
    tick();
    cmd_valid = 1'b0;
    repeat (3) tick();
    rst        = 1'b1;
    alu_outbus = 8'h5A;
    tick();
    rst = 1'b0;
    check_reset_outputs("rstwait");
    alu_finish = 1'b1;
    tick();
    alu_finish = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_eq("late_valid", 32'(rsp_valid), 0);
      check_eq("late_start", 32'(alu_start), 0);
      check_eq("late_ready", 32'(cmd_ready), 1);
      tick();
    end
    run_cmd(2'b11, 8'd77, 8'd10, 2, 0);

    for (int n = 0; n < 30; n++) begin
      logic [1:0] op;
      logic [7:0] a;
      logic [7:0] b;
      int         r;
      int         fin_at;
      op = 2'($urandom);
      a  = 8'($urandom);
      b  = 8'($urandom);
      if (op == 2'b11 && b == 8'd0) b = 8'd1;
      r = $urandom_range(0, 9);
      if (r == 0)      fin_at = 0;
      else if (r == 1) fin_at = TIMEOUT;
      else             fin_at = $urandom_range(1, 8);
      run_cmd(op, a, b, fin_at, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
